// File: rtl/bcd_to_binary_pkg.sv
// Shared constants and helpers for the BCD-to-binary converter.
// Digit thresholds live here so the adjust cell and the top agree on them.
package bcd_to_binary_pkg;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] ADJ_THRESHOLD = 4'd8;
    localparam logic [3:0] ADJ_OFFSET    = 4'd3;

    function automatic logic digit_invalid(input logic [3:0] digit);
        return digit > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit of the reverse double-dabble correction step.
// Never underflows: the smallest adjusted input is 8, giving 5.
module bcd_digit_adjust
    import bcd_to_binary_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADJ_THRESHOLD) begin
            dout = din - ADJ_OFFSET;
        end
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Iterative BCD-to-binary converter (reverse double-dabble) with a
// start/busy/done handshake and a fixed latency of 2*WIDTH+1 edges.
//
// Handshake: start is sampled only while idle; the accepting edge latches
// bcd and raises busy. done pulses for one cycle as busy falls, and bin and
// error are valid from that cycle and hold until the next done. start while
// busy is ignored; start in the done cycle is accepted.
module bcd_to_binary
    import bcd_to_binary_pkg::*;
#(
    parameter int LOG   = 3,
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [4*LOG-1:0]   bcd,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   bin,
    output logic               error
);

    localparam int CALC_W = 4*LOG + WIDTH;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_ADJUST = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [CALC_W-1:0] calc;
    logic [CALC_W-1:0] calc_adj;
    logic [4*LOG-1:0]  adj_digits;
    logic [CNT_W-1:0]  count;
    logic              invalid;
    logic              bcd_invalid;
    logic              last_iter;
    logic              ovf;
    logic              result_err;

    logic load_en;
    logic shift_en;
    logic adjust_en;
    logic finish_en;

    // Every digit of the BCD field is corrected in parallel.
    for (genvar g = 0; g < LOG; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .din  (calc[WIDTH + 4*g +: 4]),
            .dout (adj_digits[4*g +: 4])
        );
    end

    assign calc_adj   = {adj_digits, calc[WIDTH-1:0]};
    assign last_iter  = (count == CNT_W'(WIDTH - 1));
    assign ovf        = |calc[CALC_W-1:WIDTH];
    assign result_err = invalid | ovf;

    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < LOG; i++) begin
            if (digit_invalid(bcd[4*i +: 4])) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_SHIFT;
            S_SHIFT:  next_state = S_ADJUST;
            S_ADJUST: next_state = last_iter ? S_DONE : S_SHIFT;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        load_en   = 1'b0;
        shift_en  = 1'b0;
        adjust_en = 1'b0;
        finish_en = 1'b0;
        case (state)
            S_IDLE:   load_en   = start;
            S_SHIFT:  shift_en  = 1'b1;
            S_ADJUST: adjust_en = 1'b1;
            S_DONE:   finish_en = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            calc    <= '0;
            count   <= '0;
            invalid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin     <= '0;
            error   <= 1'b0;
        end else begin
            done <= finish_en;
            if (load_en) begin
                calc    <= {bcd, {WIDTH{1'b0}}};
                invalid <= bcd_invalid;
                count   <= '0;
                busy    <= 1'b1;
            end
            if (shift_en) begin
                calc <= calc >> 1;
            end
            if (adjust_en) begin
                calc  <= calc_adj;
                count <= count + CNT_W'(1);
            end
            // A bad digit still runs the full sequence so latency stays fixed.
            if (finish_en) begin
                error <= result_err;
                bin   <= result_err ? '0 : calc[WIDTH-1:0];
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: vector table, handshake corner
// cases and random conversions against a decimal-arithmetic model.
module tb_bcd_to_binary;

    localparam int LOG     = 3;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 2*WIDTH + 1;
    localparam int TIMEOUT = 60;

    typedef struct {
        logic [4*LOG-1:0] bcd;
        logic [WIDTH-1:0] bin;
        logic             err;
    } vec_t;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [4*LOG-1:0]   bcd;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   bin;
    logic               error;

    int checks;
    int errors;
    int done_cnt;

    logic [WIDTH:0] exp_q[$];

    bcd_to_binary #(.LOG(LOG), .WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .bcd     (bcd),
        .busy    (busy),
        .done    (done),
        .bin     (bin),
        .error   (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Value the caller means: decimal digits combined with plain arithmetic.
    function automatic logic [WIDTH:0] ref_model(input logic [4*LOG-1:0] v);
        int   value = 0;
        bit   bad   = 0;
        logic [3:0] d;
        for (int i = LOG - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d > 9) bad = 1;
            value = value * 10 + int'(d);
        end
        if (bad || value > (2**WIDTH - 1)) return {1'b1, {WIDTH{1'b0}}};
        return {1'b0, WIDTH'(value)};
    endfunction

    // Caller is at a negedge. Optionally pokes a start while busy.
    task automatic run_conv(input string tag, input logic [4*LOG-1:0] v,
                            input logic [WIDTH:0] exp, input int poke_at,
                            input logic [4*LOG-1:0] poke_bcd);
        int cyc;
        logic [WIDTH:0] e;
        exp_q.push_back(exp);
        start = 1'b1;
        bcd   = v;
        @(negedge clock);
        start = 1'b0;
        bcd   = 12'($urandom);
        check({tag, "_busy_after_accept"}, busy, 1'b1);
        cyc = 0;
        while (!done && cyc < TIMEOUT) begin
            if (cyc == poke_at) begin
                start = 1'b1;
                bcd   = poke_bcd;
            end
            @(negedge clock);
            start = 1'b0;
            cyc++;
        end
        check({tag, "_latency"}, cyc, LATENCY);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        e = exp_q.pop_front();
        check({tag, "_bin"}, bin, e[WIDTH-1:0]);
        check({tag, "_error"}, error, e[WIDTH]);
    endtask

    vec_t table_v[$];
    int   base;

    initial begin
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        bcd      = '0;

        table_v.push_back('{12'h255, 8'd255, 1'b0});
        table_v.push_back('{12'h256, 8'd0,   1'b1});
        table_v.push_back('{12'h1A3, 8'd0,   1'b1});
        table_v.push_back('{12'h099, 8'd99,  1'b0});
        table_v.push_back('{12'h009, 8'd9,   1'b0});
        table_v.push_back('{12'h200, 8'd200, 1'b0});
        table_v.push_back('{12'h999, 8'd0,   1'b1});
        table_v.push_back('{12'hF00, 8'd0,   1'b1});
        table_v.push_back('{12'h00A, 8'd0,   1'b1});
        table_v.push_back('{12'h001, 8'd1,   1'b0});

        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("reset_bin",   bin,   '0);
        check("reset_error", error, 1'b0);
        check("reset_busy",  busy,  1'b0);
        check("reset_done",  done,  1'b0);

        foreach (table_v[i]) begin
            run_conv($sformatf("vec%0d", i), table_v[i].bcd,
                     {table_v[i].err, table_v[i].bin}, -1, '0);
            @(negedge clock);
            check($sformatf("vec%0d_pulse_width", i), done, 1'b0);
            check($sformatf("vec%0d_bin_hold", i), bin, table_v[i].bin);
        end

        // Back-to-back: second start lands in the done cycle of the first.
        run_conv("b2b_first", 12'h000, {1'b0, 8'd0}, -1, '0);
        run_conv("b2b_second", 12'h128, {1'b0, 8'd128}, -1, '0);
        @(negedge clock);

        // start while busy is ignored and produces no extra done.
        base = done_cnt;
        run_conv("ignore", 12'h042, {1'b0, 8'd42}, 4, 12'h099);
        repeat (2*LATENCY) @(negedge clock);
        check("ignore_single_done", done_cnt - base, 1);
        check("ignore_idle_busy", busy, 1'b0);

        // Asynchronous reset mid-conversion.
        start = 1'b1;
        bcd   = 12'h123;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("abort_busy_before", busy, 1'b1);
        base = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy_async", busy, 1'b0);
        check("abort_done_async", done, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (LATENCY + 8) @(negedge clock);
        check("abort_no_done", done_cnt - base, 0);
        check("abort_bin", bin, '0);

        for (int n = 0; n < 30; n++) begin
            logic [4*LOG-1:0] v;
            v[11:8] = 4'($urandom_range(0, 2));
            v[7:4]  = 4'($urandom_range(0, 9));
            v[3:0]  = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0) v[11:8] = 4'($urandom_range(3, 9));
            run_conv($sformatf("rnd%0d", n), v, ref_model(v), -1, '0);
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Converts a packed BCD number of LOG digits into an unsigned binary value of WIDTH bits. This is the inverse of the existing binary-to-BCD converter.
- Uses iterative reverse double-dabble: shift right, then subtract 3 from each BCD digit ≥ 8.
- Sits between the keypad/score-entry logic and the game arithmetic.
- Uses an explicit start/busy/done handshake, so the conversion latency is fixed and known to the caller.

Parameters:
- LOG, 3, number of BCD digits on the input.
- WIDTH, 8, width of the binary result; also the number of shift iterations.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bcd; sampled only in IDLE.
- bcd  input  4*LOG  packed BCD, digit 0 in bits [3:0]; sampled on the accepting edge only.
- busy  output  1  high from the accepting edge until the DONE edge.
- done  output  1  one-cycle pulse; bin and error are valid from this cycle.
- bin  output  WIDTH  converted value; holds until the next done.
- error  output  1  input had a digit > 9, or the value exceeds 2^WIDTH-1; holds until the next done.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; calc, count, bin, error, busy, done all 0. This applies at any time, including mid-conversion; an interrupted conversion never produces done.
- Working register: calc, 4*LOG+WIDTH bits. count is a counter wide enough to hold WIDTH.
- States: IDLE, SHIFT, ADJUST, DONE.
- IDLE:
  - done<=0.
  - If start: calc<={bcd, WIDTH'b0}; invalid<=(any digit of bcd > 9); count<=0; busy<=1; go SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: calc<=calc>>1 (logical, zero fill); go ADJUST.
- ADJUST:
  - For every digit i in calc[WIDTH+4i +: 4]: if value ≥ 8, subtract 3. All digits are adjusted in parallel.
  - count<=count+1.
  - If count==WIDTH-1 go DONE, else go SHIFT.
- DONE:
  - ovf = |calc[4*LOG+WIDTH-1:WIDTH].
  - error<=invalid|ovf.
  - bin<=error ? 0 : calc[WIDTH-1:0].
  - done<=1; busy<=0; go IDLE.
- Latency: start accepted at edge 0; done is high in the cycle after edge 2*WIDTH+1. For WIDTH=8 that is 17 edges. Latency is constant, including error cases.
- Invalid digits do not abort the conversion. The full sequence runs and the result is forced to bin=0, error=1.
- start while busy is ignored; no queueing.
- start high in the cycle done is high (state is IDLE): accepted, giving back-to-back throughput of one conversion per 2*WIDTH+2 cycles.
- start held high continuously: conversions restart every 2*WIDTH+2 cycles.
- bcd may change after the accepting edge without effect on the result.
- Arithmetic: digit adjust is a 4-bit subtract. A digit ≥ 8 never underflows, because 8-3=5.

Decomposition:
- No shared package needed. State encodings are module-local parameters, matching the codebase's parameterised-state style.
- One natural sub-module: bcd_digit_adjust. It is a 4-bit combinational block (in ≥ 8 ? in-3 : in), instantiated LOG times with a generate loop.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles, release → bin=0, error=0, busy=0, done=0. Assert reset_n=0 asynchronously mid-cycle while busy → busy falls immediately and no done follows.
- LOG=3, WIDTH=8, bcd=12'h255, start for 1 cycle → busy for 17 edges; done pulse one cycle wide; bin=8'd255, error=0.
- bcd=12'h256 → done after 17 edges; bin=0, error=1 (overflow).
- bcd=12'h1A3 → bin=0, error=1 (invalid digit); latency unchanged at 17 edges.
- bcd=12'h000 → bin=0, error=0. Then start=1 with bcd=12'h128 in the done cycle → accepted; second done 18 edges after the first; bin=8'd128.
- During a conversion of 12'h042, pulse start with bcd=12'h099 → ignored; result bin=8'd42. Exactly one done pulse.
